// File: rtl/spi_master_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_fifo_pkg
// Brief   : Register map, bit indices and FSM states shared by the SPI master.
// Revision: 1.0 - initial release
// ============================================================================
package spi_master_fifo_pkg;

    localparam logic [2:0] c_addrCtrl   = 3'd0;
    localparam logic [2:0] c_addrPre    = 3'd1;
    localparam logic [2:0] c_addrSs     = 3'd2;
    localparam logic [2:0] c_addrStatus = 3'd3;
    localparam logic [2:0] c_addrData   = 3'd4;

    localparam int c_ctrlCpol     = 0;
    localparam int c_ctrlCpha     = 1;
    localparam int c_ctrlLsbFirst = 2;
    localparam int c_ctrlEnable   = 3;
    localparam int c_ctrlIeRx     = 4;
    localparam int c_ctrlIeTx     = 5;

    localparam int c_stBusy    = 0;
    localparam int c_stTxFull  = 1;
    localparam int c_stTxEmpty = 2;
    localparam int c_stRxFull  = 3;
    localparam int c_stRxEmpty = 4;
    localparam int c_stRxOvf   = 5;
    localparam int c_stTxOvf   = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LEAD  = 3'd2,
        S_TRAIL = 3'd3,
        S_DONE  = 3'd4
    } spiState_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_fifo_fifo.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_fifo_fifo
// Brief   : Synchronous FIFO with full/empty flags; push and pop may coincide.
// Revision: 1.0 - initial release
// ============================================================================
module spi_master_fifo_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_ptrW = $clog2(DEPTH);

    logic [DW-1:0]     r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_ptrW:0]   r_count;
    logic              w_doPush;
    logic              w_doPop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_full  = (r_count == (c_ptrW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_fifo.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_fifo
// Brief   : Register-mapped SPI master, all CPOL/CPHA modes, TX/RX FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
module spi_master_fifo
    import spi_master_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NSS   = 8,
    parameter int DEPTH = 4,
    parameter int PRE_W = 4
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [2:0]     Addr,
    input  logic           Wr,
    input  logic           Rd,
    input  logic [DW-1:0]  DataWr,
    output logic [DW-1:0]  DataRd,
    input  logic           MISO,
    output logic           MOSI,
    output logic           SCK,
    output logic [NSS-1:0] SlaveSelectors,
    output logic           Irq
);

    localparam int c_bitW = $clog2(DW);

    logic             r_cpol, r_cpha, r_lsbFirst, r_enable, r_ieRx, r_ieTx;
    logic [PRE_W-1:0] r_pre;
    logic [NSS-1:0]   r_ss;
    logic             r_rxOvf, r_txOvf;
    spiState_e        r_state, w_nextState;
    logic [PRE_W-1:0] r_preCnt;
    logic [c_bitW-1:0] r_bitCnt;
    logic [DW-1:0]    r_txShift, r_rxShift;
    logic             r_mosi, r_sck;

    logic          w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
    logic [DW-1:0] w_txHead, w_rxHead;
    logic          w_busy, w_preDone, w_lead, w_trail, w_sample, w_shift;
    logic          w_txPush, w_txPop, w_rxPush, w_rxPop;

    function automatic logic [DW-1:0] shiftTx(input logic [DW-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DW-1:1]} : {v[DW-2:0], 1'b0};
    endfunction

    function automatic logic headBit(input logic [DW-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DW-1];
    endfunction

    assign w_busy    = (r_state != S_IDLE);
    assign w_preDone = (r_preCnt == r_pre);
    assign w_lead    = (r_state == S_LEAD) & w_preDone;
    assign w_trail   = (r_state == S_TRAIL) & w_preDone;
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_shift   = r_cpha ? w_lead : w_trail;

    assign w_txPush = Wr & (Addr == c_addrData);
    assign w_txPop  = (r_state == S_LOAD);
    assign w_rxPush = (r_state == S_DONE);
    assign w_rxPop  = Rd & (Addr == c_addrData) & ~w_rxEmpty;

    spi_master_fifo_fifo #(.DW(DW), .DEPTH(DEPTH)) u_txFifo (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .i_push  (w_txPush),
        .i_pop   (w_txPop),
        .i_data  (DataWr),
        .o_data  (w_txHead),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty)
    );

    spi_master_fifo_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rxFifo (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .i_push  (w_rxPush),
        .i_pop   (w_rxPop),
        .i_data  (r_rxShift),
        .o_data  (w_rxHead),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (r_enable && !w_txEmpty) w_nextState = S_LOAD;
            S_LOAD:  w_nextState = S_LEAD;
            S_LEAD:  if (w_preDone) w_nextState = S_TRAIL;
            S_TRAIL: if (w_preDone) w_nextState = (r_bitCnt == '0) ? S_DONE : S_LEAD;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Shifter: with CPHA=0 the first bit is presented at LOAD, so the TX
    // register is pre-shifted there; every later shift edge exposes the next bit.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_preCnt  <= '0;
            r_bitCnt  <= '0;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_mosi    <= 1'b0;
            r_sck     <= 1'b0;
        end else begin
            if ((r_state == S_LEAD || r_state == S_TRAIL) && !w_preDone)
                r_preCnt <= r_preCnt + 1'b1;
            else
                r_preCnt <= '0;

            if (r_state == S_IDLE)     r_sck <= r_cpol;
            else if (w_lead || w_trail) r_sck <= ~r_sck;

            if (r_state == S_LOAD) begin
                r_bitCnt <= c_bitW'(DW-1);
                if (r_cpha) begin
                    r_txShift <= w_txHead;
                end else begin
                    r_txShift <= shiftTx(w_txHead, r_lsbFirst);
                    r_mosi    <= headBit(w_txHead, r_lsbFirst);
                end
            end else if (w_shift) begin
                r_mosi    <= headBit(r_txShift, r_lsbFirst);
                r_txShift <= shiftTx(r_txShift, r_lsbFirst);
            end

            if (w_trail && r_bitCnt != '0) r_bitCnt <= r_bitCnt - 1'b1;

            if (w_sample)
                r_rxShift <= r_lsbFirst ? {MISO, r_rxShift[DW-1:1]} : {r_rxShift[DW-2:0], MISO};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            {r_cpol, r_cpha, r_lsbFirst, r_enable, r_ieRx, r_ieTx} <= '0;
            r_pre   <= '0;
            r_ss    <= '1;
            r_rxOvf <= 1'b0;
            r_txOvf <= 1'b0;
        end else begin
            if (Wr && Addr == c_addrCtrl && !w_busy) begin
                r_cpol     <= DataWr[c_ctrlCpol];
                r_cpha     <= DataWr[c_ctrlCpha];
                r_lsbFirst <= DataWr[c_ctrlLsbFirst];
                r_enable   <= DataWr[c_ctrlEnable];
                r_ieRx     <= DataWr[c_ctrlIeRx];
                r_ieTx     <= DataWr[c_ctrlIeTx];
            end
            if (Wr && Addr == c_addrPre && !w_busy) r_pre <= DataWr[PRE_W-1:0];
            if (Wr && Addr == c_addrSs)              r_ss  <= DataWr[NSS-1:0];
            if (Wr && Addr == c_addrStatus) begin
                if (DataWr[c_stRxOvf]) r_rxOvf <= 1'b0;
                if (DataWr[c_stTxOvf]) r_txOvf <= 1'b0;
            end
            // A new overflow in the same cycle as its clear wins.
            if (w_txPush && w_txFull && !w_txPop) r_txOvf <= 1'b1;
            if (w_rxPush && w_rxFull && !w_rxPop) r_rxOvf <= 1'b1;
        end
    end

    always_comb begin
        DataRd = '0;
        case (Addr)
            c_addrCtrl: begin
                DataRd[c_ctrlCpol]     = r_cpol;
                DataRd[c_ctrlCpha]     = r_cpha;
                DataRd[c_ctrlLsbFirst] = r_lsbFirst;
                DataRd[c_ctrlEnable]   = r_enable;
                DataRd[c_ctrlIeRx]     = r_ieRx;
                DataRd[c_ctrlIeTx]     = r_ieTx;
            end
            c_addrPre: DataRd[PRE_W-1:0] = r_pre;
            c_addrSs:  DataRd[NSS-1:0]   = r_ss;
            c_addrStatus: begin
                DataRd[c_stBusy]    = w_busy;
                DataRd[c_stTxFull]  = w_txFull;
                DataRd[c_stTxEmpty] = w_txEmpty;
                DataRd[c_stRxFull]  = w_rxFull;
                DataRd[c_stRxEmpty] = w_rxEmpty;
                DataRd[c_stRxOvf]   = r_rxOvf;
                DataRd[c_stTxOvf]   = r_txOvf;
            end
            c_addrData: if (!w_rxEmpty) DataRd = w_rxHead;
            default:    DataRd = '0;
        endcase
    end

    assign MOSI           = r_mosi;
    assign SCK            = r_sck;
    assign SlaveSelectors = r_ss;
    assign Irq            = (~w_rxEmpty & r_ieRx) | (w_txEmpty & r_ieTx & ~w_busy);

endmodule
`default_nettype wire

// File: tb/tb_spi_master_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_fifo
// Brief   : Directed + randomized bench with an SPI slave model and FIFO queues.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_master_fifo;
    import spi_master_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       Rst_n, Wr, Rd;
    logic [2:0] Addr;
    logic [7:0] DataWr, DataRd;
    logic       MOSI, SCK, Irq, miso, slvMiso, loopBack;
    logic [7:0] SlaveSelectors;

    int total = 0;
    int bad   = 0;

    // Slave model state
    logic       mCpol, mCpha, mLsb;
    logic [7:0] slvTx, slvRx;
    int         slvIdx, edgeCnt;
    logic       seqQ[$];
    logic       prevSck, prevSs;

    int runQ[$];
    int gapQ[$];

    always #5 clk = ~clk;
    assign miso = loopBack ? MOSI : slvMiso;

    spi_master_fifo #(.DW(8), .NSS(8), .DEPTH(4), .PRE_W(4)) dut (
        .Clk            (clk),
        .Rst_n          (Rst_n),
        .Addr           (Addr),
        .Wr             (Wr),
        .Rd             (Rd),
        .DataWr         (DataWr),
        .DataRd         (DataRd),
        .MISO           (miso),
        .MOSI           (MOSI),
        .SCK            (SCK),
        .SlaveSelectors (SlaveSelectors),
        .Irq            (Irq)
    );

    function automatic logic bitOf(input logic [7:0] w, input int i, input logic lsb);
        logic [7:0] t;
        t = w;
        return lsb ? t[i] : t[7-i];
    endfunction

    // Behavioural SPI slave on SS[0]: presents slvTx, captures MOSI.
    initial begin
        prevSck = 1'b0;
        prevSs  = 1'b1;
        slvMiso = 1'b0;
        edgeCnt = 0;
        forever begin
            @(SCK or SlaveSelectors[0]);
            if (prevSs === 1'b1 && SlaveSelectors[0] === 1'b0) begin
                slvIdx = 0;
                slvRx  = 8'h00;
                seqQ.delete();
                if (!mCpha) slvMiso = bitOf(slvTx, 0, mLsb);
            end else if (SlaveSelectors[0] === 1'b0 && SCK !== prevSck) begin
                edgeCnt++;
                if (SCK !== mCpol) begin
                    if (!mCpha) begin
                        seqQ.push_back(MOSI);
                        slvRx = mLsb ? {MOSI, slvRx[7:1]} : {slvRx[6:0], MOSI};
                    end else begin
                        slvMiso = bitOf(slvTx, slvIdx, mLsb);
                    end
                end else begin
                    if (!mCpha) begin
                        slvIdx  = (slvIdx + 1) % 8;
                        slvMiso = bitOf(slvTx, slvIdx, mLsb);
                    end else begin
                        seqQ.push_back(MOSI);
                        slvRx  = mLsb ? {MOSI, slvRx[7:1]} : {slvRx[6:0], MOSI};
                        slvIdx = (slvIdx + 1) % 8;
                    end
                end
            end
            prevSck = SCK;
            prevSs  = SlaveSelectors[0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic regWrite(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        Addr = a; DataWr = d; Wr = 1'b1;
        @(negedge clk);
        Wr = 1'b0;
    endtask

    task automatic regRead(input logic [2:0] a, input logic pop, output logic [7:0] d);
        @(negedge clk);
        Addr = a; Rd = pop;
        #1 d = DataRd;
        @(negedge clk);
        Rd = 1'b0;
    endtask

    task automatic setMode(input logic cpol, input logic cpha, input logic lsb, input logic [3:0] pre);
        regWrite(c_addrSs, 8'hFF);
        mCpol = cpol; mCpha = cpha; mLsb = lsb;
        regWrite(c_addrCtrl, {4'b0000, 1'b1, lsb, cpha, cpol});
        regWrite(c_addrPre, {4'b0000, pre});
        regWrite(c_addrSs, 8'hFE);
    endtask

    // Records the length of each Busy run and each idle gap between runs.
    task automatic waitFrames(input int n);
        int  run = 0, gap = 0, seen = 0, cyc = 0;
        logic inRun = 1'b0;
        runQ.delete();
        gapQ.delete();
        while (seen < n && cyc < 5000) begin
            @(negedge clk);
            Addr = c_addrStatus;
            #1;
            cyc++;
            if (DataRd[c_stBusy]) begin
                if (!inRun && seen > 0) gapQ.push_back(gap);
                inRun = 1'b1;
                run++;
            end else begin
                if (inRun) begin
                    runQ.push_back(run);
                    seen++;
                    run   = 0;
                    gap   = 0;
                    inRun = 1'b0;
                end
                gap++;
            end
        end
        check("framesSeen", seen, n);
    endtask

    function automatic int frameLen(input int pre);
        return 2 + 2 * 8 * (pre + 1);
    endfunction

    initial begin
        logic [7:0] d, w, word;
        logic [7:0] txModel[$];
        logic [7:0] rxModel[$];
        logic       cpol, cpha, lsb;
        int         pre, ones, cyc;

        Rst_n = 1'b0; Wr = 1'b0; Rd = 1'b0; Addr = '0; DataWr = '0;
        loopBack = 1'b1; mCpol = 0; mCpha = 0; mLsb = 0; slvTx = 8'h00;
        repeat (3) @(negedge clk);
        Rst_n = 1'b1;

        // Reset state
        #1;
        check("rstSck", SCK, 0);
        check("rstMosi", MOSI, 0);
        check("rstSsOut", SlaveSelectors, 8'hFF);
        check("rstIrq", Irq, 0);
        regRead(c_addrStatus, 0, d); check("rstStatus", d, 8'h14);
        regRead(c_addrCtrl, 0, d);   check("rstCtrl", d, 8'h00);
        regRead(c_addrPre, 0, d);    check("rstPre", d, 8'h00);
        regRead(c_addrSs, 0, d);     check("rstSsReg", d, 8'hFF);
        regRead(c_addrData, 1, d);   check("rdEmptyData", d, 8'h00);
        regRead(c_addrStatus, 0, d); check("rdEmptyStatus", d, 8'h14);
        regRead(3'd7, 0, d);         check("unmappedRead", d, 8'h00);

        // Mode 0, Pre=0, loopback 0xA5
        setMode(0, 0, 0, 0);
        edgeCnt = 0;
        regWrite(c_addrData, 8'hA5);
        waitFrames(1);
        check("m0Busy", runQ[0], frameLen(0));
        check("m0Edges", edgeCnt, 16);
        check("m0SlaveRx", slvRx, 8'hA5);
        check("m0IdleSck", SCK, 0);
        regRead(c_addrData, 1, d); check("m0Rx", d, 8'hA5);
        regRead(c_addrStatus, 0, d); check("m0StatusAfter", d, 8'h14);

        // All four modes, Pre=3, slave returns 0x3C
        loopBack = 1'b0;
        for (int m = 0; m < 4; m++) begin
            cpol = m[1]; cpha = m[0];
            slvTx = 8'h3C;
            w = 8'($urandom);
            setMode(cpol, cpha, 0, 3);
            check($sformatf("mode%0dIdleSck", m), SCK, cpol);
            edgeCnt = 0;
            regWrite(c_addrData, w);
            waitFrames(1);
            check($sformatf("mode%0dBusy", m), runQ[0], frameLen(3));
            check($sformatf("mode%0dEdges", m), edgeCnt, 16);
            check($sformatf("mode%0dMosi", m), slvRx, w);
            check($sformatf("mode%0dSckAfter", m), SCK, cpol);
            regRead(c_addrData, 1, d); check($sformatf("mode%0dRx", m), d, 8'h3C);
        end

        // Randomized modes, prescale, bit order and data in both directions
        for (int i = 0; i < 6; i++) begin
            cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
            pre = $urandom_range(0, 2);
            slvTx = 8'($urandom);
            w = 8'($urandom);
            setMode(cpol, cpha, lsb, 4'(pre));
            edgeCnt = 0;
            regWrite(c_addrData, w);
            waitFrames(1);
            check($sformatf("rnd%0dBusy", i), runQ[0], frameLen(pre));
            check($sformatf("rnd%0dMosi", i), slvRx, w);
            regRead(c_addrData, 1, d); check($sformatf("rnd%0dRx", i), d, slvTx);
        end

        // TX overflow, back-to-back frames, then RX overflow
        loopBack = 1'b1;
        setMode(0, 0, 0, 0);
        regWrite(c_addrCtrl, 8'h00);
        txModel.delete();
        for (int i = 0; i < 5; i++) begin
            w = 8'($urandom);
            if (txModel.size() < 4) txModel.push_back(w);
            regWrite(c_addrData, w);
        end
        regRead(c_addrStatus, 0, d); check("txOvfStatus", d, 8'h52);
        regWrite(c_addrCtrl, 8'h08);
        waitFrames(4);
        for (int i = 0; i < 4; i++) check($sformatf("b2bRun%0d", i), runQ[i], frameLen(0));
        check("b2bGapCount", gapQ.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("b2bGap%0d", i), gapQ[i], 1);
        regRead(c_addrStatus, 0, d); check("rxFullStatus", d, 8'h4C);
        regWrite(c_addrStatus, 8'h40);
        rxModel = txModel;
        regWrite(c_addrData, 8'($urandom));
        waitFrames(1);
        regRead(c_addrStatus, 0, d); check("rxOvfStatus", d, 8'h2C);
        for (int i = 0; i < 4; i++) begin
            regRead(c_addrData, 1, d);
            word = rxModel.pop_front();
            check($sformatf("rxWord%0d", i), d, word);
        end
        regWrite(c_addrStatus, 8'h20);
        regRead(c_addrStatus, 0, d); check("rxOvfCleared", d, 8'h14);

        // Interrupt sources
        regWrite(c_addrCtrl, 8'h28);
        #1 check("irqTxEmpty", Irq, 1);
        regWrite(c_addrCtrl, 8'h18);
        #1 check("irqRxEmpty", Irq, 0);
        regWrite(c_addrData, 8'h5A);
        waitFrames(1);
        check("irqRxData", Irq, 1);
        regRead(c_addrData, 1, d); check("irqRxWord", d, 8'h5A);
        #1 check("irqRxDrained", Irq, 0);

        // LSB first, 0x01: first MOSI bit 1 followed by seven zeros
        setMode(0, 0, 1, 1);
        regWrite(c_addrData, 8'h01);
        waitFrames(1);
        check("lsbBitCount", seqQ.size(), 8);
        check("lsbFirstBit", seqQ[0], 1);
        ones = 0;
        for (int i = 1; i < seqQ.size(); i++) ones += int'(seqQ[i]);
        check("lsbRestZero", ones, 0);
        regRead(c_addrData, 1, d); check("lsbRx", d, 8'h01);

        // Reset mid-frame during bit 3
        setMode(0, 0, 0, 3);
        edgeCnt = 0;
        regWrite(c_addrData, 8'($urandom));
        regWrite(c_addrData, 8'($urandom));
        regWrite(c_addrData, 8'($urandom));
        cyc = 0;
        while (edgeCnt < 7 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rstMidReached", (edgeCnt >= 7), 1);
        Rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstMidSck", SCK, 0);
        check("rstMidSs", SlaveSelectors, 8'hFF);
        check("rstMidMosi", MOSI, 0);
        Addr = c_addrStatus;
        #1 check("rstMidStatus", DataRd, 8'h14);
        @(negedge clk);
        Rst_n = 1'b1;
        #1 check("rstMidIrq", Irq, 0);
        regRead(c_addrCtrl, 0, d);   check("rstMidCtrl", d, 8'h00);
        regRead(c_addrStatus, 0, d); check("rstMidIdle", d, 8'h14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
